// File: rtl/mem_stage.sv
// Memory stage of the in-order pipeline: holds one instruction, waits for load
// data from the data SRAM, and buffers that data while writeback is stalled.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_allowin,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [70:0] es_to_ms_bus,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    input  logic [31:0] data_sram_rdata,
    input  logic        data_sram_data_ok,
    output logic        ms_fwd_valid,
    output logic [4:0]  ms_fwd_dest,
    output logic        ms_fwd_pending,
    output logic [31:0] ms_fwd_data
);

    // The in-cycle "hit" case is combinational (data_hit_s); only WAIT and BUF are stored.
    typedef enum logic {
        LD_WAIT = 1'b0,
        LD_BUF  = 1'b1
    } ld_state_e;

    ld_state_e   ld_state_q, ld_state_d;
    logic        ms_valid_q, ms_valid_d;
    logic [70:0] ms_bus_q, ms_bus_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;

    logic        res_from_mem_s;
    logic        gr_we_s;
    logic [4:0]  dest_s;
    logic [31:0] alu_result_s;
    logic [31:0] pc_s;
    logic        rdata_buf_valid_s;
    logic        data_hit_s;
    logic        ms_ready_go_s;
    logic        leave_s;
    logic [31:0] final_result_s;

    assign res_from_mem_s    = ms_bus_q[70];
    assign gr_we_s           = ms_bus_q[69];
    assign dest_s            = ms_bus_q[68:64];
    assign alu_result_s      = ms_bus_q[63:32];
    assign pc_s              = ms_bus_q[31:0];
    assign rdata_buf_valid_s = (ld_state_q == LD_BUF);

    // data_ok is credited only to a load already held in the stage and not yet buffered.
    assign data_hit_s     = ms_valid_q && res_from_mem_s && data_sram_data_ok && !rdata_buf_valid_s;
    assign ms_ready_go_s  = !res_from_mem_s || data_sram_data_ok || rdata_buf_valid_s;
    assign ms_to_ws_valid = resetn && ms_valid_q && ms_ready_go_s;
    assign ms_allowin     = !resetn || !ms_valid_q || (ms_ready_go_s && ws_allowin);
    assign leave_s        = ms_to_ws_valid && ws_allowin;
    assign final_result_s = res_from_mem_s ? (rdata_buf_valid_s ? rdata_buf_q : data_sram_rdata)
                                           : alu_result_s;

    assign ms_to_ws_bus   = {gr_we_s, dest_s, final_result_s, pc_s};
    assign ms_fwd_valid   = resetn && ms_valid_q && gr_we_s && (dest_s != 5'd0);
    assign ms_fwd_pending = ms_fwd_valid && res_from_mem_s && !ms_ready_go_s;
    assign ms_fwd_dest    = dest_s;
    assign ms_fwd_data    = final_result_s;

    // Next-state logic for the instruction register and the load-data buffer.
    always_comb begin
        ms_valid_d  = ms_valid_q;
        ms_bus_d    = ms_bus_q;
        ld_state_d  = ld_state_q;
        rdata_buf_d = rdata_buf_q;

        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end else begin
            ms_valid_d = ms_valid_q;
        end

        if (es_to_ms_valid && ms_allowin) begin
            ms_bus_d = es_to_ms_bus;
        end else begin
            ms_bus_d = ms_bus_q;
        end

        case (ld_state_q)
            LD_WAIT: begin
                if (data_hit_s && !ws_allowin) begin
                    ld_state_d  = LD_BUF;
                    rdata_buf_d = data_sram_rdata;
                end else begin
                    ld_state_d  = LD_WAIT;
                end
            end
            LD_BUF: begin
                if (leave_s) begin
                    ld_state_d  = LD_WAIT;
                    rdata_buf_d = 32'd0;
                end else begin
                    ld_state_d  = LD_BUF;
                end
            end
            default: begin
                ld_state_d = LD_WAIT;
            end
        endcase
    end

    // Control state: valid flag and load-data state, cleared by reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid_q <= 1'b0;
            ld_state_q <= LD_WAIT;
        end else begin
            ms_valid_q <= ms_valid_d;
            ld_state_q <= ld_state_d;
        end
    end

    // Payload registers; their contents are masked by the valid flags after reset.
    always_ff @(posedge clk) begin
        ms_bus_q    <= ms_bus_d;
        rdata_buf_q <= rdata_buf_d;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed per-cycle vector table followed by
// a randomized stream checked against a queue-based scoreboard.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [70:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [31:0] data_sram_rdata;
    logic        data_sram_data_ok;
    logic        ms_fwd_valid;
    logic [4:0]  ms_fwd_dest;
    logic        ms_fwd_pending;
    logic [31:0] ms_fwd_data;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_rdata   (data_sram_rdata),
        .data_sram_data_ok (data_sram_data_ok),
        .ms_fwd_valid      (ms_fwd_valid),
        .ms_fwd_dest       (ms_fwd_dest),
        .ms_fwd_pending    (ms_fwd_pending),
        .ms_fwd_data       (ms_fwd_data)
    );

    typedef struct {
        logic        rst;
        logic        esv;
        logic [70:0] bus;
        logic        ws;
        logic        dok;
        logic [31:0] rd;
        logic        tov;
        logic        alw;
        logic        fv;
        logic        pd;
        logic        chk;
        logic [69:0] eb;
    } vec_t;

    typedef struct {
        logic        ld;
        logic        given;
        logic [69:0] eb;
    } sb_t;

    localparam logic [70:0] NONE = 71'd0;
    localparam logic [70:0] ALU1 = {1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h1C00_0000};
    localparam logic [70:0] ALU2 = {1'b0, 1'b1, 5'd6, 32'h0000_4321, 32'h1C00_0004};
    localparam logic [70:0] LD7  = {1'b1, 1'b1, 5'd7, 32'h0BAD_0BAD, 32'h1C00_0010};
    localparam logic [70:0] D0   = {1'b0, 1'b1, 5'd0, 32'h0000_0055, 32'h1C00_0020};
    localparam logic [69:0] E_ALU1 = {1'b1, 5'd5, 32'h0000_1234, 32'h1C00_0000};
    localparam logic [69:0] E_ALU2 = {1'b1, 5'd6, 32'h0000_4321, 32'h1C00_0004};
    localparam logic [69:0] E_D0   = {1'b1, 5'd0, 32'h0000_0055, 32'h1C00_0020};
    localparam logic [69:0] E_BEEF = {1'b1, 5'd7, 32'hDEAD_BEEF, 32'h1C00_0010};
    localparam logic [69:0] E_CAFE = {1'b1, 5'd7, 32'hCAFE_0001, 32'h1C00_0010};

    int   tests = 0;
    int   fails = 0;
    vec_t vecs[20];
    sb_t  sb_q[$];
    sb_t  f;
    logic have, e_tov, e_fv, e_pd, e_alw;
    logic s_ld, s_gw, s_esv, s_ws, s_dok;
    logic [4:0]  s_dst;
    logic [31:0] s_alu, s_ldv, s_pc, s_rd;

    function automatic vec_t mk(input logic rst, input logic esv, input logic [70:0] bus,
                                input logic ws, input logic dok, input logic [31:0] rd,
                                input logic tov, input logic alw, input logic fv,
                                input logic pd, input logic chk, input logic [69:0] eb);
        vec_t v;
        v.rst = rst; v.esv = esv; v.bus = bus; v.ws = ws; v.dok = dok; v.rd = rd;
        v.tov = tov; v.alw = alw; v.fv = fv; v.pd = pd; v.chk = chk; v.eb = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic esv, input logic [70:0] bus,
                         input logic ws, input logic dok, input logic [31:0] rd);
        resetn            = rst;
        es_to_ms_valid    = esv;
        es_to_ms_bus      = bus;
        ws_allowin        = ws;
        data_sram_data_ok = dok;
        data_sram_rdata   = rd;
    endtask

    initial begin
        drive(1'b0, 1'b0, NONE, 1'b1, 1'b0, 32'd0);

        //           rst   esv   bus   ws    dok   rdata          tov   alw   fv    pd    chk   bus
        vecs[0]  = mk(1'b0, 1'b0, NONE, 1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 70'd0);
        vecs[1]  = mk(1'b0, 1'b1, ALU1, 1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 70'd0);
        vecs[2]  = mk(1'b1, 1'b1, ALU1, 1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 70'd0);
        vecs[3]  = mk(1'b1, 1'b0, NONE, 1'b1, 1'b0, 32'd0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, E_ALU1);
        vecs[4]  = mk(1'b1, 1'b1, LD7,  1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 70'd0);
        vecs[5]  = mk(1'b1, 1'b0, NONE, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 70'd0);
        vecs[6]  = mk(1'b1, 1'b0, NONE, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 70'd0);
        vecs[7]  = mk(1'b1, 1'b0, NONE, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, E_BEEF);
        vecs[8]  = mk(1'b1, 1'b1, LD7,  1'b0, 1'b0, 32'd0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 70'd0);
        vecs[9]  = mk(1'b1, 1'b0, NONE, 1'b0, 1'b1, 32'hCAFE_0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, E_CAFE);
        vecs[10] = mk(1'b1, 1'b0, NONE, 1'b0, 1'b0, 32'd0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b1, E_CAFE);
        vecs[11] = mk(1'b1, 1'b0, NONE, 1'b1, 1'b0, 32'd0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, E_CAFE);
        vecs[12] = mk(1'b1, 1'b1, ALU1, 1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 70'd0);
        vecs[13] = mk(1'b1, 1'b1, ALU2, 1'b1, 1'b0, 32'd0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, E_ALU1);
        vecs[14] = mk(1'b1, 1'b1, D0,   1'b1, 1'b0, 32'd0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, E_ALU2);
        vecs[15] = mk(1'b1, 1'b1, LD7,  1'b1, 1'b0, 32'd0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b1, E_D0);
        vecs[16] = mk(1'b1, 1'b0, NONE, 1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 70'd0);
        vecs[17] = mk(1'b0, 1'b0, NONE, 1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 70'd0);
        vecs[18] = mk(1'b1, 1'b0, NONE, 1'b1, 1'b1, 32'h9999_9999, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 70'd0);
        vecs[19] = mk(1'b1, 1'b0, NONE, 1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 70'd0);

        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].rst, vecs[i].esv, vecs[i].bus, vecs[i].ws, vecs[i].dok, vecs[i].rd);
            @(negedge clk);
            check($sformatf("vec%0d_ctl{tov,alw,fv,pd}", i),
                  {124'd0, ms_to_ws_valid, ms_allowin, ms_fwd_valid, ms_fwd_pending},
                  {124'd0, vecs[i].tov, vecs[i].alw, vecs[i].fv, vecs[i].pd});
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_bus", i), {58'd0, ms_to_ws_bus}, {58'd0, vecs[i].eb});
                check($sformatf("vec%0d_fwd_data", i), {96'd0, ms_fwd_data}, {96'd0, vecs[i].eb[63:32]});
                check($sformatf("vec%0d_fwd_dest", i), {123'd0, ms_fwd_dest}, {123'd0, vecs[i].eb[68:64]});
            end
        end

        // Randomized stream: the scoreboard front is the instruction currently held.
        s_pc = 32'h1C00_1000;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            s_ld  = ($urandom_range(0, 2) == 0);
            s_gw  = ($urandom_range(0, 3) != 0);
            s_dst = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            s_alu = $urandom;
            s_ldv = $urandom;
            s_pc  = s_pc + 32'd4;
            s_esv = ($urandom_range(0, 3) != 0);
            s_ws  = ($urandom_range(0, 3) != 0);
            s_rd  = $urandom;
            s_dok = 1'b0;
            if (sb_q.size() != 0 && sb_q[0].ld && !sb_q[0].given) begin
                if ($urandom_range(0, 1) == 1) begin
                    s_dok         = 1'b1;
                    s_rd          = sb_q[0].eb[63:32];
                    sb_q[0].given = 1'b1;
                end
            end else begin
                s_dok = ($urandom_range(0, 5) == 0);
            end
            drive(1'b1, s_esv, {s_ld, s_gw, s_dst, s_alu, s_pc}, s_ws, s_dok, s_rd);

            @(negedge clk);
            have = (sb_q.size() != 0);
            if (have) begin
                f = sb_q[0];
            end else begin
                f.ld = 1'b0; f.given = 1'b0; f.eb = 70'd0;
            end
            e_tov = have && (!f.ld || f.given);
            e_fv  = have && f.eb[69] && (f.eb[68:64] != 5'd0);
            e_pd  = e_fv && f.ld && !f.given;
            e_alw = !have || (e_tov && s_ws);
            check($sformatf("stream%0d_ctl{tov,alw,fv,pd}", c),
                  {124'd0, ms_to_ws_valid, ms_allowin, ms_fwd_valid, ms_fwd_pending},
                  {124'd0, e_tov, e_alw, e_fv, e_pd});
            if (e_tov) begin
                check($sformatf("stream%0d_bus", c), {58'd0, ms_to_ws_bus}, {58'd0, f.eb});
            end
            if (e_fv && !e_pd) begin
                check($sformatf("stream%0d_fwd", c), {91'd0, ms_fwd_dest, ms_fwd_data},
                      {91'd0, f.eb[68:64], f.eb[63:32]});
            end
            if (e_tov && s_ws) begin
                void'(sb_q.pop_front());
            end
            if (s_esv && e_alw) begin
                f.ld    = s_ld;
                f.given = 1'b0;
                f.eb    = {s_gw, s_dst, (s_ld ? s_ldv : s_alu), s_pc};
                sb_q.push_back(f);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
